// File: rtl/gemm_result_drain.sv
// rtl/gemm_result_drain.sv - snapshot a GEMM result matrix and stream it row-major over valid/ready
module gemm_result_drain #(
    parameter int DATA_WIDTH    = 32,
    parameter int MATRIX_WIDTH  = 4,
    parameter int MATRIX_HEIGHT = 4,
    localparam int ROW_W = (MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1,
    localparam int COL_W = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] result_matrix [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ROW_W-1:0]      out_row,
    output logic [COL_W-1:0]      out_col,
    output logic                  out_last_col,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  start_ignored
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(MATRIX_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(MATRIX_WIDTH - 1);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_buf [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1];
    logic [ROW_W-1:0]      r_row;
    logic [COL_W-1:0]      r_col;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_last_col;
    logic                  r_last;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_start_ignored;

    logic                  w_capture;
    logic                  w_handshake;
    logic                  w_at_last_col;
    logic                  w_at_last;
    logic [ROW_W-1:0]      w_next_row;
    logic [COL_W-1:0]      w_next_col;

    // Capture condition, handshake and the row-major successor of the current element
    always_comb begin
        w_capture     = (r_state == S_IDLE) && start;
        w_handshake   = r_out_valid && out_ready;
        w_at_last_col = (r_col == COL_MAX);
        w_at_last     = w_at_last_col && (r_row == ROW_MAX);
        w_next_col    = w_at_last_col ? '0 : (r_col + COL_W'(1));
        w_next_row    = w_at_last_col ? (r_row + ROW_W'(1)) : r_row;
    end

    // Snapshot buffer: frozen from an accepted start until the next accepted start
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            for (int r = 0; r < MATRIX_HEIGHT; r++) begin
                for (int c = 0; c < MATRIX_WIDTH; c++) begin
                    r_buf[r][c] <= '0;
                end
            end
        end else if (w_capture) begin
            r_buf <= result_matrix;
        end
    end

    // Drain FSM with registered stream outputs and status pulses
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_state         <= S_IDLE;
            r_row           <= '0;
            r_col           <= '0;
            r_out_valid     <= 1'b0;
            r_out_data      <= '0;
            r_last_col      <= 1'b0;
            r_last          <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_start_ignored <= 1'b0;
        end else begin
            r_done          <= 1'b0;
            r_start_ignored <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // The buffer loads this same edge, so element (0,0) is
                        // taken from the value being snapshotted to keep 1-cycle latency.
                        r_state     <= S_STREAM;
                        r_row       <= '0;
                        r_col       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= result_matrix[0][0];
                        r_last_col  <= (MATRIX_WIDTH == 1);
                        r_last      <= (MATRIX_WIDTH == 1) && (MATRIX_HEIGHT == 1);
                        r_busy      <= 1'b1;
                    end
                end
                S_STREAM: begin
                    r_start_ignored <= start;
                    if (w_handshake) begin
                        if (w_at_last) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b0;
                            r_last_col  <= 1'b0;
                            r_last      <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_row      <= w_next_row;
                            r_col      <= w_next_col;
                            r_out_data <= r_buf[w_next_row][w_next_col];
                            r_last_col <= (w_next_col == COL_MAX);
                            r_last     <= (w_next_col == COL_MAX) && (w_next_row == ROW_MAX);
                        end
                    end
                end
                S_DONE: begin
                    // Any start seen here is still outside IDLE and is dropped.
                    r_start_ignored <= start;
                    r_state         <= S_IDLE;
                    r_busy          <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_row       = r_row;
    assign out_col       = r_col;
    assign out_last_col  = r_last_col;
    assign out_last      = r_last;
    assign busy          = r_busy;
    assign done          = r_done;
    assign start_ignored = r_start_ignored;

endmodule

// File: tb/tb_gemm_result_drain.sv
// tb/tb_gemm_result_drain.sv - self-checking bench for gemm_result_drain
module tb_gemm_result_drain;

    typedef logic [37:0] beat_t;

    logic        iclk;
    logic        irst;
    logic        start;
    logic [31:0] mat [0:3][0:3];
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_row;
    logic [1:0]  out_col;
    logic        out_last_col;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        start_ignored;

    int n_pass  = 0;
    int n_total = 0;

    beat_t obs[$];
    beat_t exp_q[$];
    int    done_cnt, ign_cnt, unstable, acc_first, acc_last, done_cyc;
    bit    timed_out, first_valid, busy_after_done, busy_in_done;

    gemm_result_drain #(
        .DATA_WIDTH(32),
        .MATRIX_WIDTH(4),
        .MATRIX_HEIGHT(4)
    ) dut (
        .iclk(iclk),
        .irst(irst),
        .start(start),
        .result_matrix(mat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_row(out_row),
        .out_col(out_col),
        .out_last_col(out_last_col),
        .out_last(out_last),
        .busy(busy),
        .done(done),
        .start_ignored(start_ignored)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    // Reference: row-major list of {value,row,col,last_col,last} from the matrix at start time
    function automatic void build_expected();
        exp_q.delete();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                exp_q.push_back({mat[r][c], r[1:0], c[1:0], 1'(c == 3), 1'(r == 3 && c == 3)});
            end
        end
    endfunction

    task automatic fill_pattern();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                mat[r][c] = 32'(16 * r + c);
    endtask

    task automatic fill_random();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                mat[r][c] = $urandom;
    endtask

    // Pulse start, then drive out_ready per mode and record every accepted beat
    task automatic run_stream(input int mode, input int ign_beat, input bit ign_done,
                              input int stop_after, input bit corrupt);
        beat_t cur, held;
        bit    prev_wait, ign_fired, r;
        int    after_done;
        obs.delete();
        done_cnt = 0; ign_cnt = 0; unstable = 0; timed_out = 0;
        acc_first = -1; acc_last = -1; done_cyc = -1;
        busy_after_done = 1'b1; busy_in_done = 1'b0;
        prev_wait = 1'b0; ign_fired = 1'b0; after_done = -1; held = '0;
        @(negedge iclk);
        start = 1'b1;
        @(negedge iclk);
        start = 1'b0;
        first_valid = out_valid;
        if (corrupt) mat[0][1] = 32'hDEADBEEF;
        for (int cyc = 0; cyc < 400; cyc++) begin
            start = 1'b0;
            cur = {out_data, out_row, out_col, out_last_col, out_last};
            if (prev_wait && out_valid && cur !== held) unstable++;
            if (start_ignored) ign_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                busy_in_done = busy;
                after_done = 0;
            end else if (after_done >= 0) begin
                after_done++;
                if (after_done == 1) busy_after_done = busy;
                if (after_done == 2) return;
            end
            if (ign_beat >= 0 && !ign_fired && out_valid && obs.size() == ign_beat) begin
                start = 1'b1;
                ign_fired = 1'b1;
            end
            if (ign_done && done) start = 1'b1;
            case (mode)
                0:       r = 1'b1;
                1:       r = ((cyc % 3) == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            if (out_valid && r) begin
                obs.push_back(cur);
                if (acc_first < 0) acc_first = cyc;
                acc_last = cyc;
                if (stop_after > 0 && obs.size() == stop_after) return;
            end
            prev_wait = out_valid && !r;
            held = cur;
            @(negedge iclk);
        end
        timed_out = 1'b1;
    endtask

    task automatic test_reset();
        irst = 1'b0; start = 1'b0; out_ready = 1'b0;
        fill_pattern();
        #3 irst = 1'b1;
        #1;
        n_total++;
        if ({out_valid, out_data, out_row, out_col, out_last_col, out_last, busy, done, start_ignored} !== '0)
            $display("FAIL reset_async outputs got %h/%0d/%0d/%0d valid=%b busy=%b required all 0",
                     out_data, out_row, out_col, out_last_col, out_valid, busy);
        else n_pass++;
        @(negedge iclk);
        irst = 1'b0;
        repeat (3) @(negedge iclk);
        n_total++;
        if ({out_valid, busy, done, start_ignored} !== 4'b0)
            $display("FAIL reset_idle valid/busy/done/ign got %b%b%b%b required 0000",
                     out_valid, busy, done, start_ignored);
        else n_pass++;
    endtask

    task automatic test_full_rate();
        fill_pattern();
        build_expected();
        run_stream(0, -1, 1'b0, 0, 1'b0);
        n_total++;
        if (timed_out !== 1'b0 || first_valid !== 1'b1 || acc_first !== 0)
            $display("FAIL full_rate latency timeout=%b valid=%b first_acc=%0d required 0,1,0",
                     timed_out, first_valid, acc_first);
        else n_pass++;
        n_total++;
        if (obs.size() !== 16 || acc_last - acc_first !== 15)
            $display("FAIL full_rate count beats=%0d span=%0d required 16,15", obs.size(), acc_last - acc_first);
        else n_pass++;
        for (int k = 0; k < 16; k++) begin
            n_total++;
            if (obs[k] !== exp_q[k])
                $display("FAIL full_rate beat %0d got %h required %h", k, obs[k], exp_q[k]);
            else n_pass++;
        end
        n_total++;
        if (done_cnt !== 1 || done_cyc !== acc_last + 1 || busy_in_done !== 1'b1 || busy_after_done !== 1'b0)
            $display("FAIL full_rate done cnt=%0d cyc=%0d busy_in=%b busy_after=%b required 1,%0d,1,0",
                     done_cnt, done_cyc, busy_in_done, busy_after_done, acc_last + 1);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        fill_pattern();
        build_expected();
        run_stream(1, -1, 1'b0, 0, 1'b0);
        n_total++;
        if (timed_out !== 1'b0 || obs.size() !== 16 || unstable !== 0 || done_cnt !== 1)
            $display("FAIL backpressure summary timeout=%b beats=%0d unstable=%0d done=%0d required 0,16,0,1",
                     timed_out, obs.size(), unstable, done_cnt);
        else n_pass++;
        for (int k = 0; k < 16; k++) begin
            n_total++;
            if (obs[k] !== exp_q[k])
                $display("FAIL backpressure beat %0d got %h required %h", k, obs[k], exp_q[k]);
            else n_pass++;
        end
    endtask

    task automatic test_snapshot();
        fill_pattern();
        build_expected();
        run_stream(0, -1, 1'b0, 0, 1'b1);
        n_total++;
        if (obs[1] !== exp_q[1] || mat[0][1] !== 32'hDEADBEEF)
            $display("FAIL snapshot beat(0,1) got %h required %h", obs[1], exp_q[1]);
        else n_pass++;
        n_total++;
        if (obs.size() !== 16 || obs != exp_q)
            $display("FAIL snapshot stream beats=%0d required 16 matching", obs.size());
        else n_pass++;
    endtask

    task automatic test_ignored_start();
        fill_random();
        build_expected();
        run_stream(0, 5, 1'b1, 0, 1'b0);
        n_total++;
        if (ign_cnt !== 2 || done_cnt !== 1 || obs.size() !== 16 || obs != exp_q)
            $display("FAIL ignored_start ign=%0d done=%0d beats=%0d required 2,1,16 matching",
                     ign_cnt, done_cnt, obs.size());
        else n_pass++;
        n_total++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL ignored_start idle valid=%b busy=%b required 0,0", out_valid, busy);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        bit saw_done, saw_valid;
        fill_pattern();
        build_expected();
        run_stream(0, -1, 1'b0, 8, 1'b0);
        @(posedge iclk);
        #2;
        n_total++;
        if (out_valid !== 1'b1 || {out_row, out_col} !== 4'b1000)
            $display("FAIL midreset pre valid=%b rc=%b required 1,1000", out_valid, {out_row, out_col});
        else n_pass++;
        irst = 1'b1;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL midreset async valid=%b busy=%b required 0,0", out_valid, busy);
        else n_pass++;
        @(negedge iclk);
        @(negedge iclk);
        irst = 1'b0;
        saw_done = 1'b0; saw_valid = 1'b0;
        repeat (5) begin
            @(negedge iclk);
            if (done) saw_done = 1'b1;
            if (out_valid) saw_valid = 1'b1;
        end
        n_total++;
        if (saw_done !== 1'b0 || saw_valid !== 1'b0)
            $display("FAIL midreset after done=%b valid=%b required 0,0", saw_done, saw_valid);
        else n_pass++;
        run_stream(0, -1, 1'b0, 0, 1'b0);
        n_total++;
        if (obs.size() !== 16 || obs != exp_q || done_cnt !== 1)
            $display("FAIL midreset restart beats=%0d first=%h required 16 from %h", obs.size(), obs[0], exp_q[0]);
        else n_pass++;
    endtask

    task automatic test_random_streams();
        for (int it = 0; it < 4; it++) begin
            fill_random();
            build_expected();
            run_stream(2, -1, 1'b0, 0, 1'b0);
            n_total++;
            if (timed_out !== 1'b0 || obs.size() !== 16 || obs != exp_q || unstable !== 0 || done_cnt !== 1)
                $display("FAIL random_%0d timeout=%b beats=%0d unstable=%0d done=%0d required 0,16,0,1",
                         it, timed_out, obs.size(), unstable, done_cnt);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_backpressure();
        test_snapshot();
        test_ignored_start();
        test_reset_midstream();
        test_random_streams();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
